// File: rtl/serial_score_subtractor.sv
// Bit-serial subtractor used to deduct penalties from a running score.
// diff = minuend - subtrahend - bin, one bit per clock, LSB first, through
// a single shared full-subtractor cell.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is in IDLE or DONE. busy=1 marks the WIDTH processing cycles, and
// start is ignored while busy=1. done is a one-cycle pulse. diff, bout and
// underflow are valid from done and stay stable until the next result
// completes.
module serial_score_subtractor #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             underflow,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  // a_q is the minuend and also the result shift register. Each cycle its
  // LSB is consumed and the new difference bit enters at the MSB, so after
  // WIDTH cycles it holds the complete difference.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Shared full-subtractor cell working on the current LSBs.
  logic             d_bit;
  logic             brw_next;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell and the shifted result it produces.
  always_comb begin
    d_bit     = a_q[0] ^ b_q[0] ^ brw_q;
    brw_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    res_shift = {d_bit, a_q[WIDTH-1:1]};
  end

  // Next-state logic: accept, bit-serial run, and result publication.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = minuend;
          b_d     = subtrahend;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = res_shift;
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        brw_d = brw_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          bout_d  = brw_next;
          diff_d  = (SATURATE && brw_next) ? '0 : res_shift;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign underflow = bout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_score_subtractor.sv
// Directed bench for serial_score_subtractor. A wrapping instance and a
// saturating instance share the same stimulus and are checked side by side.
module tb_serial_score_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] minuend = '0;
  logic [W-1:0] subtrahend = '0;
  logic         bin = 1'b0;

  logic         busy_w, done_w, bout_w, uf_w;
  logic [W-1:0] diff_w;
  logic [1:0]   st_w;
  logic         busy_s, done_s, bout_s, uf_s;
  logic [W-1:0] diff_s;
  logic [1:0]   st_s;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Clock and reset block.
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  serial_score_subtractor #(.WIDTH(W), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .minuend(minuend),
    .subtrahend(subtrahend), .bin(bin), .busy(busy_w), .done(done_w),
    .diff(diff_w), .bout(bout_w), .underflow(uf_w), .state_dbg(st_w)
  );

  serial_score_subtractor #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .minuend(minuend),
    .subtrahend(subtrahend), .bin(bin), .busy(busy_s), .done(done_s),
    .diff(diff_s), .bout(bout_s), .underflow(uf_s), .state_dbg(st_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request before an edge; t0 is the accepting edge's cycle number.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input bit keep, output int t0);
    @(negedge clk);
    start      = 1'b1;
    minuend    = a;
    subtrahend = b;
    bin        = bi;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!keep) start = 1'b0;
  endtask

  // Wait (bounded) for done on the wrapping instance; returns its cycle.
  task automatic wait_done(output int t);
    t = -1000;
    for (int k = 0; k < 4 * W; k++) begin
      @(posedge clk);
      #1;
      if (done_w) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Check the result pair of both instances at the done cycle.
  task automatic chk_result(input string tag, input logic [W-1:0] exp_w,
                            input logic [W-1:0] exp_s, input logic exp_b);
    chk({tag, "_diff_wrap"}, diff_w, exp_w);
    chk({tag, "_diff_sat"},  diff_s, exp_s);
    chk({tag, "_bout_wrap"}, bout_w, exp_b);
    chk({tag, "_bout_sat"},  bout_s, exp_b);
    chk({tag, "_underflow"}, uf_w,   exp_b);
    chk({tag, "_done_sat"},  done_s, 1'b1);
  endtask

  initial begin
    int t0, t1, t2, ndone;

    // Reset state.
    #12;
    chk("rst_busy", busy_w, 1'b0);
    chk("rst_done", done_w, 1'b0);
    chk("rst_diff", diff_w, 0);
    chk("rst_bout", bout_w, 1'b0);
    chk("rst_state", st_w, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 100 - 37 = 63; done is first seen after the 8th edge past acceptance.
    do_start(8'd100, 8'd37, 1'b0, 1'b0, t0);
    chk("run_busy", busy_w, 1'b1);
    chk("run_done", done_w, 1'b0);
    wait_done(t1);
    chk("lat_100_37", t1 - t0, W);
    chk("busy_in_done", busy_w, 1'b0);
    chk_result("r100_37", 8'd63, 8'd63, 1'b0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done_w, 1'b0);
    chk("idle_after_done", st_w, 2'd0);
    chk("diff_held_idle", diff_w, 63);

    // 5 - 9: wraps to 252, saturates to 0; previous result held during RUN.
    do_start(8'd5, 8'd9, 1'b0, 1'b0, t0);
    repeat (3) @(posedge clk);
    #1;
    chk("diff_held_run", diff_w, 63);
    wait_done(t1);
    chk("lat_5_9", t1 - t0, W);
    chk_result("r5_9", 8'd252, 8'd0, 1'b1);

    // 255 - 255 = 0, no borrow.
    do_start(8'd255, 8'd255, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk_result("r255_255", 8'd0, 8'd0, 1'b0);

    // Start pulsed during RUN with 10 - 1 is ignored.
    do_start(8'd100, 8'd37, 1'b0, 1'b0, t0);
    repeat (2) @(posedge clk);
    #1;
    start      = 1'b1;
    minuend    = 8'd10;
    subtrahend = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(t1);
    chk("lat_ignore", t1 - t0, W);
    chk_result("r_ignore", 8'd63, 8'd63, 1'b0);

    // 0 - 0 - 1 = all ones with borrow.
    do_start(8'd0, 8'd0, 1'b1, 1'b0, t0);
    wait_done(t1);
    chk_result("r0_0_b1", 8'd255, 8'd0, 1'b1);

    // Reset during RUN: outputs clear at once and no done follows.
    do_start(8'd100, 8'd37, 1'b0, 1'b0, t0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_w, 1'b0);
    chk("abort_diff", diff_w, 0);
    chk("abort_bout", bout_w, 1'b0);
    chk("abort_uf",   uf_w,   1'b0);
    chk("abort_state", st_w, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(posedge clk);
      #1;
      if (done_w || done_s) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_start(8'd20, 8'd5, 1'b0, 1'b0, t0);
    wait_done(t1);
    chk("lat_20_5", t1 - t0, W);
    chk_result("r20_5", 8'd15, 8'd15, 1'b0);

    // Back-to-back: start held high, second request accepted in DONE.
    do_start(8'd50, 8'd20, 1'b0, 1'b1, t0);
    minuend    = 8'd40;
    subtrahend = 8'd45;
    wait_done(t1);
    chk("lat_b2b_first", t1 - t0, W);
    chk_result("r50_20", 8'd30, 8'd30, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_accepted", busy_w, 1'b1);
    chk("b2b_done_low", done_w, 1'b0);
    wait_done(t2);
    chk("b2b_spacing", t2 - t1, W + 1);
    chk_result("r40_45", 8'd251, 8'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
